// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the pipeline W stage has priority and late results are queued.
// A queue head that waits STARVE_MAX cycles is forced out with a one-cycle W-stage stall.
module wb_arbiter #(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWriteW,
   input  logic [4:0]  RdW,
   input  logic [31:0] ResultW,
   input  logic        late_valid,
   input  logic [4:0]  late_rd,
   input  logic [31:0] late_data,
   output logic        late_ready,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_wd,
   output logic        stall_req
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned AgeW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;

   typedef enum logic [1:0] {StIdle, StQueued, StForce} state_e;

   state_e            state_q, state_d;
   logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [AgeW-1:0]   age_q, age_d;
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [4:0]        q_rd_q   [DEPTH];
   logic [31:0]       q_data_q [DEPTH];

   logic pipe_wr, accept, head_vld, grant_pipe, bypass, deq, enq, we;

   always_comb begin
      pipe_wr    = RegWriteW && (RdW != 5'd0);
      late_ready = (count_q < CntW'(DEPTH)) || !rst_n;
      accept     = late_valid && late_ready;
      head_vld   = vld_q[head_q];
      grant_pipe = 1'b0;
      bypass     = 1'b0;
      deq        = 1'b0;
      we         = 1'b0;
      rf_rd      = 5'd0;
      rf_wd      = 32'd0;

      case (state_q)
         StForce: begin
            // Pipeline is held off by stall_req; the head owns the port.
            we    = head_vld;
            rf_rd = q_rd_q[head_q];
            rf_wd = q_data_q[head_q];
            deq   = (count_q != '0);
         end
         StIdle, StQueued: begin
            if (pipe_wr) begin
               grant_pipe = 1'b1;
               we         = 1'b1;
               rf_rd      = RdW;
               rf_wd      = ResultW;
            end
            if (state_q == StQueued) begin
               if (!head_vld) begin
                  deq = 1'b1;
               end else if (!pipe_wr) begin
                  we    = 1'b1;
                  rf_rd = q_rd_q[head_q];
                  rf_wd = q_data_q[head_q];
                  deq   = 1'b1;
               end
            end else if (!pipe_wr && accept && (late_rd != 5'd0)) begin
               bypass = 1'b1;
               we     = 1'b1;
               rf_rd  = late_rd;
               rf_wd  = late_data;
            end
         end
         default: ;
      endcase

      rf_we = we && rst_n;
      enq   = accept && (late_rd != 5'd0) && !bypass && !(grant_pipe && (late_rd == RdW));

      // Younger pipeline write to the same register supersedes any queued late result.
      vld_d = vld_q;
      if (grant_pipe) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (q_rd_q[i] == RdW) vld_d[i] = 1'b0;
         end
      end
      head_d = head_q;
      tail_d = tail_q;
      if (deq) begin
         vld_d[head_q] = 1'b0;
         head_d        = head_q + 1'b1;
      end
      if (enq) begin
         vld_d[tail_q] = 1'b1;
         tail_d        = tail_q + 1'b1;
      end
      count_d = count_q + CntW'(enq) - CntW'(deq);

      age_d = age_q;
      if (deq) begin
         age_d = '0;
      end else if ((state_q == StQueued) && head_vld) begin
         age_d = age_q + 1'b1;
      end

      if ((state_q == StQueued) && (age_d == AgeW'(STARVE_MAX))) begin
         state_d = StForce;
      end else begin
         state_d = (count_d != '0) ? StQueued : StIdle;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         age_q   <= '0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         age_q   <= age_d;
         vld_q   <= vld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         q_rd_q[tail_q]   <= late_rd;
         q_data_q[tail_q] <= late_data;
      end
   end

   assign stall_req = (state_q == StForce);

endmodule
